// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for the E stage (HI = remainder, LO = quotient).
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes on the next cycle.
module div_unit #(
   parameter int unsigned       WIDTH            = 32,
   parameter int unsigned       CTRL_W           = 5,
   parameter logic [CTRL_W-1:0] ALU_SIGNED_DIV   = CTRL_W'(26),
   parameter logic [CTRL_W-1:0] ALU_UNSIGNED_DIV = CTRL_W'(27)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [CTRL_W-1:0] alu_controlE,
   input  logic [WIDTH-1:0]  src_aE,
   input  logic [WIDTH-1:0]  src_bE,
   input  logic              annulE,
   output logic              stall_divE,
   output logic              result_validE,
   output logic [WIDTH-1:0]  hi_outE,
   output logic [WIDTH-1:0]  lo_outE,
   output logic              busyE
);
   localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
   state_t r_state, w_next;

   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_hi, r_lo;
   logic             r_sign_q, r_sign_r, r_div0, r_valid, r_busy;

   logic             w_is_sdiv, w_is_div, w_b_zero, w_start, w_last, w_qbit;
   logic [WIDTH:0]   w_shift, w_diff;
   logic [WIDTH-1:0] w_abs_a, w_abs_b, w_rem_nxt, w_quo_nxt;

   assign w_is_sdiv = (alu_controlE == ALU_SIGNED_DIV);
   assign w_is_div  = w_is_sdiv || (alu_controlE == ALU_UNSIGNED_DIV);
   assign w_b_zero  = (src_bE == '0);
   assign w_abs_a   = (w_is_sdiv && src_aE[WIDTH-1]) ? -src_aE : src_aE;
   assign w_abs_b   = (w_is_sdiv && src_bE[WIDTH-1]) ? -src_bE : src_bE;

   // One restoring step: shift in the next dividend bit, subtract if it fits.
   assign w_shift   = {r_rem, r_quo[WIDTH-1]};
   assign w_diff    = w_shift - {1'b0, r_dvs};
   assign w_qbit    = ~w_diff[WIDTH];
   assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
`ifdef DIV_ZERO_FAST_EN
               w_next = w_b_zero ? S_DONE : S_RUN;
`else
               w_next = S_RUN;
`endif
            end
         end
         S_RUN: begin
            if (annulE)      w_next = S_IDLE;
            else if (w_last) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Stall is combinational so the start cycle itself holds the pipeline.
   always_comb begin
      w_start    = 1'b0;
      w_last     = 1'b0;
      stall_divE = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_start    = w_is_div && !annulE;
            stall_divE = resetn && w_start;
         end
         S_RUN: begin
            w_last     = (r_cnt == LAST_CNT);
            stall_divE = resetn;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_div0   <= 1'b0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_valid <= (w_next == S_DONE);
         r_busy  <= (w_next != S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_cnt    <= '0;
                  r_rem    <= '0;
                  r_quo    <= w_abs_a;
                  r_dvs    <= w_abs_b;
                  r_sign_q <= w_is_sdiv && (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
                  r_sign_r <= w_is_sdiv && src_aE[WIDTH-1];
                  r_div0   <= w_b_zero;
`ifdef DIV_ZERO_FAST_EN
                  if (w_b_zero) begin
                     r_lo <= '1;
                     r_hi <= src_aE;
                  end
`endif
               end
            end
            S_RUN: begin
               if (!annulE) begin
                  r_rem <= w_rem_nxt;
                  r_quo <= w_quo_nxt;
                  r_cnt <= r_cnt + CNT_W'(1);
                  // For x/0 the remainder ends as |x|, so the remainder fix-up yields raw x.
                  if (w_last) begin
                     r_lo <= r_div0 ? '1 : (r_sign_q ? -w_quo_nxt : w_quo_nxt);
                     r_hi <= r_sign_r ? -w_rem_nxt : w_rem_nxt;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign result_validE = r_valid;
   assign busyE         = r_busy;
   assign hi_outE       = r_hi;
   assign lo_outE       = r_lo;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed test-plan cases plus randomized traffic checked against a cycle-level reference model.
module tb_div_unit;
   localparam int unsigned       WIDTH  = 32;
   localparam int unsigned       CTRL_W = 5;
   localparam logic [CTRL_W-1:0] SDIV   = 5'd26;
   localparam logic [CTRL_W-1:0] UDIV   = 5'd27;
   localparam logic [CTRL_W-1:0] NOP    = 5'd0;
`ifdef DIV_ZERO_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic              clk;
   logic              resetn;
   logic [CTRL_W-1:0] alu_controlE;
   logic [WIDTH-1:0]  src_aE, src_bE;
   logic              annulE;
   logic              stall_divE, result_validE, busyE;
   logic [WIDTH-1:0]  hi_outE, lo_outE;

   int n_checks = 0;
   int n_fail   = 0;

   div_unit #(
      .WIDTH(WIDTH), .CTRL_W(CTRL_W), .ALU_SIGNED_DIV(SDIV), .ALU_UNSIGNED_DIV(UDIV)
   ) u_dut (
      .clk(clk), .resetn(resetn), .alu_controlE(alu_controlE),
      .src_aE(src_aE), .src_bE(src_bE), .annulE(annulE),
      .stall_divE(stall_divE), .result_validE(result_validE),
      .hi_outE(hi_outE), .lo_outE(lo_outE), .busyE(busyE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_div(input logic [CTRL_W-1:0] c);
      return (c == SDIV) || (c == UDIV);
   endfunction

   // Architectural result {hi, lo} of a divide, straight from the arithmetic definition.
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      logic [31:0] q, r;
      if (b == 32'h0) begin
         q = 32'hFFFF_FFFF;
         r = a;
      end else if (sgn) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
         end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   // Reference model: cycles left until the result, a done flag, and the architectural HI/LO.
   int          m_left;
   bit          m_done;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         p_hi   <= '0;
         p_lo   <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
      end else if (m_left != 0) begin
         if (annulE) m_left <= 0;
         else if (m_left == 1) begin
            m_left <= 0;
            m_done <= 1'b1;
            m_hi   <= p_hi;
            m_lo   <= p_lo;
         end else m_left <= m_left - 1;
      end else if (is_div(alu_controlE) && !annulE) begin
         {p_hi, p_lo} <= ref_div(src_aE, src_bE, alu_controlE == SDIV);
         if (FAST && src_bE == '0) begin
            m_done <= 1'b1;
            {m_hi, m_lo} <= ref_div(src_aE, src_bE, alu_controlE == SDIV);
         end else m_left <= int'(WIDTH);
      end
   end

   function automatic logic exp_stall();
      return resetn && ((m_left != 0) ||
                        (!m_done && is_div(alu_controlE) && !annulE));
   endfunction

   always @(negedge clk) begin
      chk("cmp stall", 32'(stall_divE), 32'(exp_stall()));
      chk("cmp valid", 32'(result_validE), 32'(m_done));
      chk("cmp busy", 32'(busyE), 32'((m_left != 0) || m_done));
      chk("cmp hi", hi_outE, m_hi);
      chk("cmp lo", lo_outE, m_lo);
   end

   task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic [CTRL_W-1:0] code,
                          output logic [31:0] lo, output logic [31:0] hi, output int stalls);
      bit got = 1'b0;
      stalls = 0;
      lo = '0;
      hi = '0;
      @(posedge clk); #2;
      alu_controlE = code; src_aE = a; src_bE = b; annulE = 1'b0;
      @(negedge clk);
      if (stall_divE) stalls++;
      @(posedge clk); #2;
      alu_controlE = NOP; src_aE = $urandom; src_bE = $urandom;
      for (int i = 0; i < 100 && !got; i++) begin
         @(negedge clk);
         if (stall_divE) stalls++;
         if (result_validE) begin
            got = 1'b1;
            lo  = lo_outE;
            hi  = hi_outE;
         end
      end
      chk("result arrived", 32'(got), 32'd1);
   endtask

   task automatic do_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [CTRL_W-1:0] code, input logic [31:0] exp_lo,
                          input logic [31:0] exp_hi, input int exp_stalls);
      logic [31:0] lo, hi;
      int          stalls;
      run_div(a, b, code, lo, hi, stalls);
      chk({name, " lo"}, lo, exp_lo);
      chk({name, " hi"}, hi, exp_hi);
      chk({name, " stall cycles"}, 32'(stalls), 32'(exp_stalls));
   endtask

   function automatic logic [31:0] rand_op();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return 32'h0 - 32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   initial begin
      int          seen;
      logic [CTRL_W-1:0] c;
      resetn = 1'b0; alu_controlE = NOP; src_aE = '0; src_bE = '0; annulE = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset lo", lo_outE, 32'h0);
      chk("reset hi", hi_outE, 32'h0);
      chk("reset valid", 32'(result_validE), 32'h0);
      chk("reset busy", 32'(busyE), 32'h0);
      @(posedge clk); #2 resetn = 1'b1;

      do_case("u100/7", 32'd100, 32'd7, UDIV, 32'd14, 32'd2, 33);
      do_case("s-7/2", 32'hFFFF_FFF9, 32'd2, SDIV, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
      do_case("u-7/2", 32'hFFFF_FFF9, 32'd2, UDIV, 32'h7FFF_FFFC, 32'd1, 33);
      do_case("s ovf", 32'h8000_0000, 32'hFFFF_FFFF, SDIV, 32'h8000_0000, 32'h0, 33);
      do_case("b2b 9/3", 32'd9, 32'd3, SDIV, 32'd3, 32'd0, 33);
      do_case("s-7/0", 32'hFFFF_FFF9, 32'd0, SDIV, 32'hFFFF_FFFF, 32'hFFFF_FFF9, FAST ? 1 : 33);
      do_case("0x1234/0", 32'h1234, 32'd0, UDIV, 32'hFFFF_FFFF, 32'h1234, FAST ? 1 : 33);

      // Annul in RUN cycle 10 of 50/5.
      @(posedge clk); #2 alu_controlE = UDIV; src_aE = 32'd50; src_bE = 32'd5;
      @(posedge clk); #2 alu_controlE = NOP;
      repeat (9) @(posedge clk);
      #2 annulE = 1'b1;
      @(posedge clk); #2 annulE = 1'b0;
      @(negedge clk);
      chk("annul busy", 32'(busyE), 32'h0);
      chk("annul stall", 32'(stall_divE), 32'h0);
      chk("annul lo kept", lo_outE, 32'hFFFF_FFFF);
      chk("annul hi kept", hi_outE, 32'h1234);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (result_validE) seen++;
      end
      chk("annul no valid", 32'(seen), 32'h0);

      // Reset in RUN cycle 20.
      @(posedge clk); #2 alu_controlE = SDIV; src_aE = 32'd50; src_bE = 32'd5;
      @(posedge clk); #2 alu_controlE = NOP;
      repeat (19) @(posedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("rst-run stall", 32'(stall_divE), 32'h0);
      chk("rst-run valid", 32'(result_validE), 32'h0);
      chk("rst-run busy", 32'(busyE), 32'h0);
      chk("rst-run lo", lo_outE, 32'h0);
      chk("rst-run hi", hi_outE, 32'h0);
      @(posedge clk); #2 resetn = 1'b1;
      do_case("u8/3", 32'd8, 32'd3, UDIV, 32'd2, 32'd2, 33);

      // Random traffic: mixed codes, operands with corner values, occasional annul.
      for (int n = 0; n < 3000; n++) begin
         @(posedge clk); #2;
         case ($urandom_range(0, 9))
            0, 1, 2, 3: alu_controlE = SDIV;
            4, 5, 6, 7: alu_controlE = UDIV;
            default: begin
               c = CTRL_W'($urandom_range(0, 31));
               alu_controlE = is_div(c) ? NOP : c;
            end
         endcase
         annulE = ($urandom_range(0, 63) == 0);
         src_aE = rand_op();
         src_bE = rand_op();
      end
      @(posedge clk); #2 alu_controlE = NOP; annulE = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage; consumer of the ALU control code produced in decode.
- Starts when the E-stage control equals ALU_SIGNED_DIV or ALU_UNSIGNED_DIV, from the ALU define header.
- Stalls the pipeline while dividing, then presents quotient (LO) and remainder (HI) for the HI/LO write.

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 5, width of the ALU control code.

Ports:
- clk  input  1  pipeline clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- alu_controlE  input  CTRL_W  ALU control code of the instruction in E.
- src_aE  input  WIDTH  dividend (rs value after forwarding).
- src_bE  input  WIDTH  divisor (rt value after forwarding).
- annulE  input  1  flush of E (exception/eret); aborts any division in progress.
- stall_divE  output  1  holds F/D/E while a division is outstanding.
- result_validE  output  1  one-cycle pulse; hi_outE/lo_outE valid this cycle.
- hi_outE  output  WIDTH  remainder.
- lo_outE  output  WIDTH  quotient.
- busyE  output  1  FSM not in IDLE.

Behaviour:
- Clock and reset: one clock; reset is asynchronous, active-low (resetn).
- Reset values: FSM=IDLE, counter=0, all internal registers 0, hi_outE=0, lo_outE=0, result_validE=0, busyE=0.
- stall_divE is combinational: 1 when (IDLE and div code present and !annulE) or state==RUN; otherwise 0.
- IDLE: when a div code is present and annulE=0, latch operands:
  - signed: latch |a| and |b|, sign_q=a[31]^b[31], sign_r=a[31].
  - unsigned: latch raw values, signs=0.
  - Then go to RUN with counter=0.
- RUN: one restoring iteration per cycle over a WIDTH+1-bit partial remainder. After WIDTH iterations (counter==WIDTH-1), apply signs and go to DONE:
  - q = sign_q ? -q : q
  - r = sign_r ? -r : r
- DONE: result_validE=1 for exactly this cycle; hi_outE/lo_outE hold the results until the next start; stall_divE=0 so the instruction advances at this edge; next state IDLE.
- Latency: stall asserted for WIDTH+1 cycles (start cycle plus WIDTH RUN cycles); result on cycle WIDTH+1 after the start.
- Divide by zero (src_bE==0): runs the full latency. Result: lo_outE=all ones, hi_outE=src_aE as latched raw, independent of signedness. Sign fix-up is suppressed.
- Overflow case (signed 0x80000000 / -1): lo_outE=0x80000000, hi_outE=0. No exception.
- annulE in RUN: return to IDLE next edge, no result_validE, hi_outE/lo_outE unchanged. annulE in IDLE blocks the start. annulE in DONE: result_validE still pulses; the HI/LO write gating is the consumer's job.
- Non-div codes in IDLE: no action, stall_divE=0.
- resetn low at any time: immediate return to reset values. No partial result is exposed.
- Back-to-back divides: the second starts in the IDLE cycle after DONE.

Optional Feature:
- Macro: DIV_ZERO_FAST_EN.
- Defined: a divisor of 0 goes IDLE->DONE directly. Stall is asserted only in the start cycle; result_validE pulses the next cycle with the same values as above.
- Undefined: divide by zero takes the full WIDTH+1-cycle latency.

Test Plan:
- Unsigned 100/7 (ALU_UNSIGNED_DIV) -> stall_divE high 33 cycles, then result_validE=1 for 1 cycle, lo=14, hi=2.
- Signed 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned same operands -> lo=0x7FFFFFFC, hi=1.
- Signed 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. Back-to-back second divide 9/3 starts the cycle after DONE -> lo=3, hi=0.
- 0x1234/0 -> lo=0xFFFFFFFF, hi=0x1234. Latency is 33 cycles without DIV_ZERO_FAST_EN, and result on the 2nd cycle with it.
- 50/5 with annulE pulsed in RUN cycle 10 -> FSM IDLE next cycle, no result_validE, hi/lo keep their prior values, stall_divE drops.
- resetn driven low in RUN cycle 20 -> all outputs 0 immediately. After release, 8/3 -> lo=2, hi=2.
